// File: rtl/shifter_arbiter.sv
// Two-requester, round-robin arbitrated 32-bit shifter (SLL/SRL/SRA/PASS).
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module shifter_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_s,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_s,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_y,
  output logic        res_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [31:0] a_reg;
  logic [4:0]  s_reg;
  logic        id_reg;
  logic [31:0] res_y_reg;
  logic        res_id_reg;
  logic        last_grant_reg;

  logic [1:0]  valid_vec;
  logic [1:0]  ready_vec;
  logic [1:0]  op_vec [2];
  logic [31:0] a_vec [2];
  logic [4:0]  s_vec [2];
  logic        grant_next;
  logic        accept;
  logic [31:0] shift_next;

  assign valid_vec = {req1_valid, req0_valid};
  assign op_vec[0] = req0_op;
  assign op_vec[1] = req1_op;
  assign a_vec[0]  = req0_a;
  assign a_vec[1]  = req1_a;
  assign s_vec[0]  = req0_s;
  assign s_vec[1]  = req1_s;

  // On a tie the requester that did not win last time goes next; a lone requester always wins.
  assign grant_next = (&valid_vec) ? ~last_grant_reg : valid_vec[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign ready_vec[gi] = !rst && (state_reg == IDLE) && valid_vec[gi]
                             && (grant_next == (gi == 1));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;

  always_comb begin
    shift_next = a_reg;
    case (op_reg)
      2'b00:   shift_next = a_reg << s_reg;
      2'b01:   shift_next = a_reg >> s_reg;
      2'b10:   shift_next = $unsigned($signed(a_reg) >>> s_reg);
      default: shift_next = a_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= 2'b00;
      a_reg          <= 32'd0;
      s_reg          <= 5'd0;
      id_reg         <= 1'b0;
      res_y_reg      <= 32'd0;
      res_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg         <= op_vec[grant_next];
            a_reg          <= a_vec[grant_next];
            s_reg          <= s_vec[grant_next];
            id_reg         <= grant_next;
            last_grant_reg <= grant_next;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          res_y_reg  <= shift_next;
          res_id_reg <= id_reg;
          state_reg  <= RESP;
        end
        RESP: begin
          // Result stays parked until the consumer takes it.
          if (res_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign res_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign res_y     = res_y_reg;
  assign res_id    = res_id_reg;

endmodule
